// File: rtl/atm_account_server.sv
// atm_account_server: bank-side responder for ATM controller transactions.
// It holds a single account with a balance, PIN verification with a sticky
// lockout, and session gating. It handles one request at a time over
// valid/ready handshakes, moving through IDLE -> EXEC -> RESP.
// Optional feature macro: ATM_MINI_STMT_EN adds a HIST_DEPTH-entry ring of
// successful withdraw/deposit amounts, which MINI_STMT reads back.
module atm_account_server #(
    parameter logic [15:0] BALANCE_INIT  = 16'd1000,
    parameter logic [15:0] PIN_CODE      = 16'h1234,
    parameter int unsigned MAX_PIN_TRIES = 3,
    parameter int unsigned HIST_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_amount,
    input  logic [15:0] req_pin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_status,
    output logic [15:0] rsp_old_balance,
    output logic [15:0] rsp_new_balance,
    output logic [15:0] rsp_mini,
    output logic        locked
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] OP_END_SESSION = 4'h0;
    localparam logic [3:0] OP_WITHDRAW    = 4'h1;
    localparam logic [3:0] OP_DEPOSIT     = 4'h2;
    localparam logic [3:0] OP_BALANCE     = 4'h3;
    localparam logic [3:0] OP_VERIFY_PIN  = 4'h4;
    localparam logic [3:0] OP_MINI_STMT   = 4'h5;

    localparam logic [2:0] S_OK           = 3'd0;
    localparam logic [2:0] S_BAD_PIN      = 3'd1;
    localparam logic [2:0] S_LOCKED       = 3'd2;
    localparam logic [2:0] S_NO_SESSION   = 3'd3;
    localparam logic [2:0] S_INSUFFICIENT = 3'd4;
    localparam logic [2:0] S_OVERFLOW     = 3'd5;
    localparam logic [2:0] S_BAD_OP       = 3'd6;

    localparam logic [3:0] MAX_TRIES = 4'(MAX_PIN_TRIES);

    // Reject configurations the counter and ring pointer widths cannot represent.
    if (MAX_PIN_TRIES < 1 || MAX_PIN_TRIES > 7 || HIST_DEPTH < 2 ||
        (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_params
        $error("atm_account_server: MAX_PIN_TRIES must be 1..7, HIST_DEPTH a power of 2 >= 2");
    end

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [15:0] amount_q;
    logic [15:0] pin_q;

    logic [15:0] balance;
    logic [2:0]  fail_cnt;
    logic        session;

    logic [2:0]  nxt_status;
    logic [15:0] nxt_balance;
    logic [2:0]  nxt_fail;
    logic        nxt_session;
    logic        nxt_locked;
    logic [16:0] dep_sum;
    logic [3:0]  fail_inc;

`ifdef ATM_MINI_STMT_EN
    localparam int unsigned HIST_AW = $clog2(HIST_DEPTH);

    logic [15:0]        hist [HIST_DEPTH];
    logic [HIST_AW-1:0] wr_ptr;
    logic [HIST_AW-1:0] rd_ptr;
    logic               hist_we;
    logic [15:0]        hist_wdata;
    logic [15:0]        nxt_mini;
    logic [15:0]        rsp_mini_q;
`endif

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    // Handshake sequencing and capture of the accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            amount_q <= '0;
            pin_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        amount_q <= req_amount;
                        pin_q    <= req_pin;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: state <= ST_RESP;
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Evaluate the latched op against the account state (first matching rule wins).
    always_comb begin
        nxt_status  = S_OK;
        nxt_balance = balance;
        nxt_fail    = fail_cnt;
        nxt_session = session;
        nxt_locked  = locked;
        dep_sum     = {1'b0, balance} + {1'b0, amount_q};
        fail_inc    = {1'b0, fail_cnt} + 4'd1;
`ifdef ATM_MINI_STMT_EN
        hist_we     = 1'b0;
        hist_wdata  = '0;
        nxt_mini    = '0;
        rd_ptr      = wr_ptr - HIST_AW'(1) - amount_q[HIST_AW-1:0];
`endif
        if (locked) begin
            if (op_q == OP_END_SESSION) nxt_session = 1'b0;
            else                        nxt_status  = S_LOCKED;
        end else begin
            case (op_q)
                OP_VERIFY_PIN: begin
                    if (pin_q == PIN_CODE) begin
                        nxt_session = 1'b1;
                        nxt_fail    = '0;
                    end else begin
                        nxt_fail = fail_inc[2:0];
                        if (fail_inc >= MAX_TRIES) begin
                            nxt_locked = 1'b1;
                            nxt_status = S_LOCKED;
                        end else begin
                            nxt_status = S_BAD_PIN;
                        end
                    end
                end
                OP_END_SESSION: nxt_session = 1'b0;
                OP_WITHDRAW: begin
                    if (!session) begin
                        nxt_status = S_NO_SESSION;
                    end else if (amount_q > balance) begin
                        nxt_status = S_INSUFFICIENT;
                    end else begin
                        nxt_balance = balance - amount_q;
`ifdef ATM_MINI_STMT_EN
                        hist_we    = 1'b1;
                        hist_wdata = {1'b1, amount_q[14:0]};
`endif
                    end
                end
                OP_DEPOSIT: begin
                    if (!session) begin
                        nxt_status = S_NO_SESSION;
                    end else if (dep_sum[16]) begin
                        nxt_status = S_OVERFLOW;
                    end else begin
                        nxt_balance = dep_sum[15:0];
`ifdef ATM_MINI_STMT_EN
                        hist_we    = 1'b1;
                        hist_wdata = {1'b0, amount_q[14:0]};
`endif
                    end
                end
                OP_BALANCE: begin
                    if (!session) nxt_status = S_NO_SESSION;
                end
`ifdef ATM_MINI_STMT_EN
                OP_MINI_STMT: begin
                    if (!session) nxt_status = S_NO_SESSION;
                    else          nxt_mini   = hist[rd_ptr];
                end
`endif
                default: nxt_status = S_BAD_OP;
            endcase
        end
    end

    // Commit account state and register the response in the single EXEC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            balance         <= BALANCE_INIT;
            fail_cnt        <= '0;
            session         <= 1'b0;
            locked          <= 1'b0;
            rsp_status      <= '0;
            rsp_old_balance <= '0;
            rsp_new_balance <= '0;
        end else if (state == ST_EXEC) begin
            balance         <= nxt_balance;
            fail_cnt        <= nxt_fail;
            session         <= nxt_session;
            locked          <= nxt_locked;
            rsp_status      <= nxt_status;
            rsp_old_balance <= balance;
            rsp_new_balance <= nxt_balance;
        end
    end

`ifdef ATM_MINI_STMT_EN
    // Mini-statement ring; wr_ptr points at the oldest slot, overwritten next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            wr_ptr     <= '0;
            rsp_mini_q <= '0;
        end else if (state == ST_EXEC) begin
            rsp_mini_q <= nxt_mini;
            if (hist_we) begin
                hist[wr_ptr] <= hist_wdata;
                wr_ptr       <= wr_ptr + HIST_AW'(1);
            end
        end
    end

    assign rsp_mini = rsp_mini_q;
`else
    assign rsp_mini = '0;
`endif

endmodule

// File: tb/tb_atm_account_server.sv
// Directed testbench for atm_account_server with hand-computed expectations.
// The mini-statement checks run only when ATM_MINI_STMT_EN is defined.
module tb_atm_account_server;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_amount;
    logic [15:0] req_pin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [15:0] rsp_old_balance;
    logic [15:0] rsp_new_balance;
    logic [15:0] rsp_mini;
    logic        locked;

    int unsigned n_vec;
    int unsigned n_miss;

    atm_account_server #(
        .BALANCE_INIT (16'd1000),
        .PIN_CODE     (16'h1234),
        .MAX_PIN_TRIES(3),
        .HIST_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_amount     (req_amount),
        .req_pin        (req_pin),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_old_balance(rsp_old_balance),
        .rsp_new_balance(rsp_new_balance),
        .rsp_mini       (rsp_mini),
        .locked         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request and return just after the accepting clock edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] amt, input logic [15:0] pin);
        int unsigned cyc;
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_amount = amt;
        req_pin    = pin;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, sampling on the falling edge.
    task automatic wait_rsp();
        int unsigned cyc;
        cyc = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic [3:0] op, input logic [15:0] amt,
                        input logic [15:0] pin, input logic [2:0] st,
                        input logic [15:0] old_b, input logic [15:0] new_b);
        issue(op, amt, pin);
        wait_rsp();
        check({tag, "_status"}, {29'd0, rsp_status}, {29'd0, st});
        check({tag, "_old"}, {16'd0, rsp_old_balance}, {16'd0, old_b});
        check({tag, "_new"}, {16'd0, rsp_new_balance}, {16'd0, new_b});
        finish_rsp();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0]  hold_st;
        logic [15:0] hold_new;
        n_vec      = 0;
        n_miss     = 0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_amount = '0;
        req_pin    = '0;
        rsp_ready  = 1'b0;
        reset      = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_status", {29'd0, rsp_status}, 32'd0);
        check("rst_old", {16'd0, rsp_old_balance}, 32'd0);
        check("rst_new", {16'd0, rsp_new_balance}, 32'd0);
        check("rst_mini", {16'd0, rsp_mini}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        reset = 1'b1;

        // Session gating and the main balance flow
        xact("bal_nosess", 4'h3, 16'd0, 16'h0, 3'd3, 16'd1000, 16'd1000);
        xact("wd_nosess", 4'h1, 16'd5, 16'h0, 3'd3, 16'd1000, 16'd1000);
        xact("pin_ok", 4'h4, 16'd0, 16'h1234, 3'd0, 16'd1000, 16'd1000);
        xact("wd300", 4'h1, 16'd300, 16'h0, 3'd0, 16'd1000, 16'd700);
        xact("wd701", 4'h1, 16'd701, 16'h0, 3'd4, 16'd700, 16'd700);
        xact("wd700", 4'h1, 16'd700, 16'h0, 3'd0, 16'd700, 16'd0);
        xact("dep1", 4'h2, 16'd1, 16'h0, 3'd0, 16'd0, 16'd1);
        xact("dep_ovf", 4'h2, 16'd65535, 16'h0, 3'd5, 16'd1, 16'd1);
        xact("dep_max", 4'h2, 16'd65534, 16'h0, 3'd0, 16'd1, 16'd65535);
        xact("dep0", 4'h2, 16'd0, 16'h0, 3'd0, 16'd65535, 16'd65535);
        xact("wd0", 4'h1, 16'd0, 16'h0, 3'd0, 16'd65535, 16'd65535);
        xact("bal", 4'h3, 16'd0, 16'h0, 3'd0, 16'd65535, 16'd65535);
        xact("badop7", 4'h7, 16'd0, 16'h0, 3'd6, 16'd65535, 16'd65535);
`ifndef ATM_MINI_STMT_EN
        xact("mini_disabled", 4'h5, 16'd0, 16'h0, 3'd6, 16'd65535, 16'd65535);
        check("mini_disabled_val", {16'd0, rsp_mini}, 32'd0);
`endif

        // Response back-pressure: fields stay stable and a new request waits
        issue(4'h1, 16'd535, 16'h0);
        wait_rsp();
        check("stall_status", {29'd0, rsp_status}, 32'd0);
        check("stall_new", {16'd0, rsp_new_balance}, 32'd65000);
        hold_st  = rsp_status;
        hold_new = rsp_new_balance;
        req_valid = 1'b1;
        req_op    = 4'h3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_ready", {31'd0, req_ready}, 32'd0);
            check("stall_hold_st", {29'd0, rsp_status}, {29'd0, hold_st});
            check("stall_hold_new", {16'd0, rsp_new_balance}, {16'd0, hold_new});
        end
        finish_rsp();
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp();
        check("held_req_status", {29'd0, rsp_status}, 32'd0);
        check("held_req_old", {16'd0, rsp_old_balance}, 32'd65000);
        check("held_req_new", {16'd0, rsp_new_balance}, 32'd65000);
        finish_rsp();

        // End session, then PIN lockout
        xact("end", 4'h0, 16'd0, 16'h0, 3'd0, 16'd65000, 16'd65000);
        xact("bal_after_end", 4'h3, 16'd0, 16'h0, 3'd3, 16'd65000, 16'd65000);
        xact("bad_pin1", 4'h4, 16'd0, 16'h0000, 3'd1, 16'd65000, 16'd65000);
        check("not_locked1", {31'd0, locked}, 32'd0);
        xact("bad_pin2", 4'h4, 16'd0, 16'h0000, 3'd1, 16'd65000, 16'd65000);
        xact("bad_pin3", 4'h4, 16'd0, 16'h0000, 3'd2, 16'd65000, 16'd65000);
        check("locked_set", {31'd0, locked}, 32'd1);
        xact("locked_pin", 4'h4, 16'd0, 16'h1234, 3'd2, 16'd65000, 16'd65000);
        xact("locked_bal", 4'h3, 16'd0, 16'h0, 3'd2, 16'd65000, 16'd65000);
        xact("locked_end", 4'h0, 16'd0, 16'h0, 3'd0, 16'd65000, 16'd65000);
        check("locked_sticky", {31'd0, locked}, 32'd1);

        // Reset clears the lock and restores the balance
        do_reset();
        check("unlocked", {31'd0, locked}, 32'd0);
        xact("bal_after_rst", 4'h3, 16'd0, 16'h0, 3'd3, 16'd1000, 16'd1000);

        // Reset during EXEC aborts the withdraw
        xact("pin_ok2", 4'h4, 16'd0, 16'h1234, 3'd0, 16'd1000, 16'd1000);
        issue(4'h1, 16'd500, 16'h0);
        check("exec_no_valid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        #2;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        xact("bal_abort_nosess", 4'h3, 16'd0, 16'h0, 3'd3, 16'd1000, 16'd1000);
        xact("pin_ok3", 4'h4, 16'd0, 16'h1234, 3'd0, 16'd1000, 16'd1000);
        xact("bal_abort", 4'h3, 16'd0, 16'h0, 3'd0, 16'd1000, 16'd1000);

`ifdef ATM_MINI_STMT_EN
        // Mini statement: ring of the last four successful amounts
        xact("mini_empty", 4'h5, 16'd0, 16'h0, 3'd0, 16'd1000, 16'd1000);
        check("mini_empty_val", {16'd0, rsp_mini}, 32'd0);
        xact("mdep1", 4'h2, 16'd1, 16'h0, 3'd0, 16'd1000, 16'd1001);
        xact("mdep2", 4'h2, 16'd2, 16'h0, 3'd0, 16'd1001, 16'd1003);
        xact("mdep3", 4'h2, 16'd3, 16'h0, 3'd0, 16'd1003, 16'd1006);
        xact("mdep4", 4'h2, 16'd4, 16'h0, 3'd0, 16'd1006, 16'd1010);
        xact("mdep5", 4'h2, 16'd5, 16'h0, 3'd0, 16'd1010, 16'd1015);
        xact("mini0", 4'h5, 16'd0, 16'h0, 3'd0, 16'd1015, 16'd1015);
        check("mini0_val", {16'd0, rsp_mini}, 32'd5);
        xact("mini3", 4'h5, 16'd3, 16'h0, 3'd0, 16'd1015, 16'd1015);
        check("mini3_val", {16'd0, rsp_mini}, 32'd2);
        xact("mwd3", 4'h1, 16'd3, 16'h0, 3'd0, 16'd1015, 16'd1012);
        xact("mini_wd", 4'h5, 16'd0, 16'h0, 3'd0, 16'd1012, 16'd1012);
        check("mini_wd_val", {16'd0, rsp_mini}, 32'h8003);
        xact("mini_bal", 4'h3, 16'd0, 16'h0, 3'd0, 16'd1012, 16'd1012);
        check("mini_zero_other", {16'd0, rsp_mini}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
